// File: rtl/udp_tx_channel_arbiter_pkg.sv
// Shared types and constants for the UDP TX channel arbiter and its RX-side sibling.
package udp_tx_channel_arbiter_pkg;
  localparam int CH_IDX_W          = 3;
  localparam int DEF_MAX_PKT_BYTES = 1472;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ABORT = 2'd3
  } arb_state_e;
endpackage

// File: rtl/udp_tx_channel_arbiter_if.sv
// Byte-lane AXI-Stream bundle; NUM_CH lanes share one interface instance.
interface udp_tx_channel_arbiter_if #(
  parameter int NUM_CH = 1,
  parameter int DW     = 8
);
  logic [NUM_CH*DW-1:0] tdata;
  logic [NUM_CH-1:0]    tvalid;
  logic [NUM_CH-1:0]    tlast;
  logic [NUM_CH-1:0]    tready;

  modport master (output tdata, tvalid, tlast, input  tready);
  modport slave  (input  tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/udp_tx_channel_arbiter_rr_pick_next.sv
// Round-robin picker: first set request searching upward from last_grant+1 (mod N).
module rr_pick_next #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [IDX_W-1:0] next_grant,
  output logic             any_req
);
  always_comb begin
    int c;
    c          = 0;
    next_grant = '0;
    any_req    = 1'b0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(last_grant) + i) % N;
      if (!any_req && req[c]) begin
        any_req    = 1'b1;
        next_grant = c[IDX_W-1:0];
      end
    end
  end
endmodule

// File: rtl/udp_tx_channel_arbiter.sv
// Packet-granular round-robin mux of NUM_CHANNELS byte streams onto the UDP TX path.
// Optional mid-packet stall abort is enabled by defining UDP_TX_ARB_TIMEOUT_EN.
module udp_tx_channel_arbiter
  import udp_tx_channel_arbiter_pkg::*;
#(
  parameter int NUM_CHANNELS   = 8,
  parameter int DATAWIDTH      = 8,
  parameter int MAX_PKT_BYTES  = DEF_MAX_PKT_BYTES,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  axis_aclk,
  input  logic                  axis_aresetn,
  udp_tx_channel_arbiter_if.slave  s_axis,
  udp_tx_channel_arbiter_if.master m_axis,
  output logic [CH_IDX_W-1:0]   m_axis_tdest,
  output logic                  busy,
  output logic [15:0]           trunc_count
);
  localparam int CNT_W = $clog2(MAX_PKT_BYTES + 1);

  arb_state_e              state;
  logic [CH_IDX_W-1:0]     grant, last_grant, pick;
  logic                    any_req;
  logic [CNT_W-1:0]        byte_cnt;
  logic [NUM_CHANNELS-1:0] gsel;
  logic                    g_vld, g_last, max_beat, xfer_hs;
  logic [DATAWIDTH-1:0]    g_data;

  rr_pick_next #(.N(NUM_CHANNELS), .IDX_W(CH_IDX_W)) u_pick (
    .req        (s_axis.tvalid),
    .last_grant (last_grant),
    .next_grant (pick),
    .any_req    (any_req)
  );

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_sel
    assign gsel[i] = (grant == CH_IDX_W'(i));
  end

  always_comb begin
    g_vld  = 1'b0;
    g_last = 1'b0;
    g_data = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (gsel[i]) begin
        g_vld  = s_axis.tvalid[i];
        g_last = s_axis.tlast[i];
        g_data = s_axis.tdata[i*DATAWIDTH +: DATAWIDTH];
      end
    end
  end

  // byte_cnt holds beats already accepted, so this flags the MAX_PKT_BYTES-th beat
  assign max_beat = (byte_cnt == CNT_W'(MAX_PKT_BYTES - 1));
  assign xfer_hs  = (state == ST_XFER) && g_vld && m_axis.tready[0];
  assign busy     = (state != ST_IDLE);

  always_comb begin
    m_axis.tvalid = '0;
    m_axis.tdata  = '0;
    m_axis.tlast  = '0;
    s_axis.tready = '0;
    m_axis_tdest  = '0;
    case (state)
      ST_XFER: begin
        m_axis.tvalid = g_vld;
        m_axis.tdata  = g_data;
        m_axis.tlast  = g_last | max_beat;
        s_axis.tready = gsel & {NUM_CHANNELS{m_axis.tready[0]}};
        m_axis_tdest  = grant;
      end
      ST_DRAIN: begin
        s_axis.tready = gsel;
        m_axis_tdest  = grant;
      end
`ifdef UDP_TX_ARB_TIMEOUT_EN
      ST_ABORT: begin
        m_axis.tvalid = 1'b1;
        m_axis.tlast  = 1'b1;
        m_axis_tdest  = grant;
      end
`endif
      default: ;
    endcase
  end

`ifdef UDP_TX_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;
`endif

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state       <= ST_IDLE;
      grant       <= '0;
      last_grant  <= CH_IDX_W'(NUM_CHANNELS - 1);
      byte_cnt    <= '0;
      trunc_count <= '0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      stall_cnt   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (any_req) begin
          grant      <= pick;
          last_grant <= pick;
          byte_cnt   <= '0;
          state      <= ST_XFER;
`ifdef UDP_TX_ARB_TIMEOUT_EN
          stall_cnt  <= '0;
`endif
        end
        ST_XFER: begin
          if (xfer_hs) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (g_last) state <= ST_IDLE;
            else if (max_beat) begin
              state <= ST_DRAIN;
              if (trunc_count != 16'hFFFF) trunc_count <= trunc_count + 16'd1;
            end
          end
`ifdef UDP_TX_ARB_TIMEOUT_EN
          if (g_vld) stall_cnt <= '0;
          else if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            stall_cnt <= '0;
            state     <= ST_ABORT;
          end else stall_cnt <= stall_cnt + STALL_W'(1);
`endif
        end
        ST_DRAIN: if (g_vld && g_last) state <= ST_IDLE;
`ifdef UDP_TX_ARB_TIMEOUT_EN
        ST_ABORT: if (m_axis.tready[0]) state <= ST_DRAIN;
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_udp_tx_channel_arbiter.sv
// Randomized scoreboard bench for udp_tx_channel_arbiter.
module tb_udp_tx_channel_arbiter;
  import udp_tx_channel_arbiter_pkg::*;
  localparam int NCH = 8, DW = 8, MAXB = 1472, LIM = 6000;

  typedef struct packed { logic last; logic [7:0] data; } beat_t;
  typedef struct packed { logic [2:0] dest; logic [7:0] data; logic last; logic trunc; } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  udp_tx_channel_arbiter_if #(.NUM_CH(NCH), .DW(DW)) s_if ();
  udp_tx_channel_arbiter_if #(.NUM_CH(1),   .DW(DW)) m_if ();
  logic [2:0]  tdest;
  logic        busy;
  logic [15:0] trunc;

  udp_tx_channel_arbiter #(.NUM_CHANNELS(NCH), .DATAWIDTH(DW), .MAX_PKT_BYTES(MAXB),
                           .TIMEOUT_CYCLES(16)) dut (
    .axis_aclk(clk), .axis_aresetn(rst_n), .s_axis(s_if), .m_axis(m_if),
    .m_axis_tdest(tdest), .busy(busy), .trunc_count(trunc));

  beat_t       src_q[NCH][$];
  int unsigned mlen[NCH][$];
  logic [7:0]  mdat[NCH][$];
  exp_t        exp_q[$];
  bit          mid[NCH];
  int          n_chk, n_fail, m_last, m_trunc, bp_pct;
  bit          gap_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic add_pkt(input int ch, input int len, input bit ramp);
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = ramp ? 8'((k + 1) * 17) : 8'($urandom);
      src_q[ch].push_back({k == len - 1, b});
      mdat[ch].push_back(b);
    end
    mlen[ch].push_back(len);
  endtask

  // Reference: every loaded packet is visible at once, so service order is plain RR over non-empty lists
  task automatic schedule();
    int p, len;
    bit any;
    logic [7:0] b;
    do begin
      any = 0; p = 0;
      for (int i = 1; i <= NCH; i++) begin
        p = (m_last + i) % NCH;
        if (mlen[p].size() != 0) begin any = 1; break; end
      end
      if (any) begin
        len = mlen[p].pop_front();
        for (int k = 0; k < len; k++) begin
          b = mdat[p].pop_front();
          if (k < MAXB)
            exp_q.push_back('{dest: 3'(p), data: b, last: (k == len - 1) || (k == MAXB - 1),
                              trunc: (len > MAXB) && (k == MAXB - 1)});
        end
        if (len > MAXB && m_trunc < 65535) m_trunc++;
        m_last = p;
      end
    end while (any);
  endtask

  function automatic bit src_pending();
    for (int c = 0; c < NCH; c++) if (src_q[c].size() != 0) return 1;
    return 0;
  endfunction

  task automatic wait_done(input string nm);
    int cyc = 0;
    while ((exp_q.size() != 0 || src_pending() || busy) && cyc < LIM) begin
      @(posedge clk); cyc++;
    end
    repeat (3) @(posedge clk);
    n_chk++;
    if (cyc >= LIM) begin
      n_fail++;
      $display("FAIL %s_timeout actual=%0d_left required=0", nm, exp_q.size());
    end
  endtask

  // Source driver: inputs change only 1 time unit after posedge; accepts sampled at negedge
  initial begin
    beat_t b;
    s_if.tvalid = '0; s_if.tdata = '0; s_if.tlast = '0; m_if.tready = '0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < NCH; c++)
        if (rst_n && s_if.tvalid[c] && s_if.tready[c] && src_q[c].size() != 0) begin
          b = src_q[c].pop_front();
          mid[c] = !b.last;
        end
      @(posedge clk); #1;
      for (int c = 0; c < NCH; c++) begin
        if (rst_n && src_q[c].size() != 0 && !(gap_en && mid[c] && $urandom_range(99) < 30)) begin
          s_if.tvalid[c] = 1'b1;
          s_if.tlast[c]  = src_q[c][0].last;
          s_if.tdata[c*DW +: DW] = src_q[c][0].data;
        end else begin
          s_if.tvalid[c] = 1'b0;
          s_if.tlast[c]  = 1'b0;
        end
      end
      m_if.tready[0] = rst_n && ($urandom_range(99) < 32'(bp_pct));
    end
  end

  // Monitor: pops the scoreboard on each output handshake
  initial begin
    exp_t e;
    bit gapchk;
    int idx;
    gapchk = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin gapchk = 0; continue; end
      if (gapchk) begin
        chk("gap_busy", busy, 0);
        chk("gap_valid", m_if.tvalid, 0);
        gapchk = 0;
      end
      if (s_if.tready != '0) begin
        idx = 0;
        for (int c = 0; c < NCH; c++) if (s_if.tready[c]) idx = c;
        chk("rdy_onehot", $onehot(s_if.tready), 1);
        chk("rdy_chan", idx, tdest);
      end
      if (m_if.tvalid[0] && m_if.tready[0]) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_beat actual=%0h required=none", m_if.tdata);
        end else begin
          e = exp_q.pop_front();
          chk("dest", tdest, e.dest);
          chk("data", m_if.tdata, e.data);
          chk("last", m_if.tlast, e.last);
          gapchk = e.last && !e.trunc;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0; m_last = NCH - 1; m_trunc = 0; bp_pct = 100; gap_en = 0;
    repeat (3) @(posedge clk); #1;
    chk("rst_valid", m_if.tvalid, 0);   chk("rst_last", m_if.tlast, 0);
    chk("rst_data", m_if.tdata, 0);     chk("rst_dest", tdest, 0);
    chk("rst_busy", busy, 0);           chk("rst_ready", s_if.tready, 0);
    chk("rst_trunc", trunc, 0);
    rst_n = 1'b1;
    @(posedge clk);

    add_pkt(0, 4, 1); schedule(); wait_done("p_ch0");
    add_pkt(2, 3, 0); add_pkt(5, 3, 0); add_pkt(7, 3, 0); add_pkt(2, 3, 0);
    schedule(); wait_done("p_rr");
    add_pkt(1, 1500, 0); schedule(); wait_done("p_trunc");
    chk("trunc_after_1500", trunc, m_trunc);
    add_pkt(3, MAXB, 0); schedule(); wait_done("p_exact");
    chk("trunc_after_exact", trunc, m_trunc);
    bp_pct = 50; gap_en = 1;
    add_pkt(6, 64, 0); schedule(); wait_done("p_bp");

    for (int it = 0; it < 20; it++) begin
      bp_pct = $urandom_range(100, 30);
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(1) == 1) begin
          add_pkt(c, $urandom_range(24, 1), 0);
          if ($urandom_range(3) == 0) add_pkt(c, $urandom_range(6, 1), 0);
        end
      add_pkt($urandom_range(NCH - 1), 1, 0);
      schedule(); wait_done("p_rand");
    end
    chk("trunc_after_rand", trunc, m_trunc);

`ifdef UDP_TX_ARB_TIMEOUT_EN
    bp_pct = 100; gap_en = 0;
    src_q[3].push_back({1'b0, 8'hA1}); src_q[3].push_back({1'b0, 8'hA2});
    exp_q.push_back('{dest: 3'd3, data: 8'hA1, last: 1'b0, trunc: 1'b0});
    exp_q.push_back('{dest: 3'd3, data: 8'hA2, last: 1'b0, trunc: 1'b0});
    exp_q.push_back('{dest: 3'd3, data: 8'h00, last: 1'b1, trunc: 1'b1});
    m_last = 3;
    for (int cyc = 0; cyc < 200 && exp_q.size() != 0; cyc++) @(posedge clk);
    chk("abort_left", exp_q.size(), 0);
    chk("abort_drain_busy", busy, 1);
    src_q[3].push_back({1'b0, 8'h55}); src_q[3].push_back({1'b1, 8'h66});
    wait_done("p_abort");
    chk("trunc_after_abort", trunc, m_trunc);
`endif

    bp_pct = 100; gap_en = 0;
    add_pkt(4, 30, 0); schedule();
    for (int cyc = 0; cyc < 200 && exp_q.size() > 20; cyc++) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", m_if.tvalid, 0);  chk("arst_last", m_if.tlast, 0);
    chk("arst_data", m_if.tdata, 0);    chk("arst_dest", tdest, 0);
    chk("arst_busy", busy, 0);          chk("arst_ready", s_if.tready, 0);
    chk("arst_trunc", trunc, 0);
    for (int c = 0; c < NCH; c++) begin
      src_q[c].delete(); mlen[c].delete(); mdat[c].delete(); mid[c] = 0;
    end
    exp_q.delete();
    m_last = NCH - 1; m_trunc = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    add_pkt(5, 5, 0); add_pkt(0, 6, 0); schedule(); wait_done("p_post_rst");
    chk("trunc_post_rst", trunc, m_trunc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
